// File: rtl/trit_packer_if.sv
// rtl/trit_packer_if.sv - trit input / byte output handshake bundle for trit_packer.
interface trit_packer_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_trit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic       done;
  logic       err;

  modport master (
    output start, in_valid, in_trit, out_ready,
    input  in_ready, out_valid, out_byte, out_last, done, err
  );

  modport slave (
    input  start, in_valid, in_trit, out_ready,
    output in_ready, out_valid, out_byte, out_last, done, err
  );
endinterface

// File: rtl/trit_packer.sv
// rtl/trit_packer.sv - packs 2-bit trits five per byte (t0 + 3t1 + 9t2 + 27t3 + 81t4).
module trit_packer #(
  parameter int N_COEFFS       = 701,
  parameter int TRITS_PER_BYTE = 5
) (
  input  logic          clk,
  input  logic          rst,
  trit_packer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_t;

  localparam logic [9:0] N_FULL   = 10'(N_COEFFS);
  localparam logic [9:0] N_LAST   = 10'(N_COEFFS - 1);
  localparam logic [2:0] LAST_POS = 3'(TRITS_PER_BYTE - 1);

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [6:0] weight_q, weight_d;
  logic [2:0] pos_q, pos_d;
  logic [9:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] trit_val;
  logic       last_byte;

  assign last_byte = (cnt_q == N_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      weight_q <= 7'd1;
      pos_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      weight_q <= weight_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    weight_d = weight_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    // Illegal code 11 contributes nothing to the byte; only err records it.
    trit_val = 8'd0;
    if (bus.in_trit == 2'd1) trit_val = {1'b0, weight_q};
    else if (bus.in_trit == 2'd2) trit_val = {weight_q, 1'b0};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = COLLECT;
          acc_d    = '0;
          weight_d = 7'd1;
          pos_d    = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          acc_d    = acc_q + trit_val;
          // Weight only needs to be right for the next trit of the same byte (max 81).
          weight_d = weight_q + {weight_q[5:0], 1'b0};
          pos_d    = pos_q + 3'd1;
          cnt_d    = cnt_q + 10'd1;
          if (bus.in_trit == 2'd3) err_d = 1'b1;
          if (pos_q == LAST_POS || cnt_q == N_LAST) state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (last_byte) begin
            state_d = DONE;
          end else begin
            state_d  = COLLECT;
            acc_d    = '0;
            weight_d = 7'd1;
            pos_d    = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_byte  = (state_q == EMIT) ? acc_q : 8'd0;
  assign bus.out_last  = (state_q == EMIT) && last_byte;
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;

endmodule
